// File: rtl/inference_tile_engine_if.sv
// Tile-input and row-output streams of the tile inference engine.
// The engine connects through the slave modport and the producer/consumer through master.
interface inference_tile_engine_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
);
    localparam int ROW_WIDTH = (N > 1) ? $clog2(N) : 1;

    logic                         tile_valid;
    logic                         tile_ready;
    logic [N*N*DATA_WIDTH-1:0]    a_data;
    logic [N*N*DATA_WIDTH-1:0]    b_data;

    logic                         out_valid;
    logic                         out_ready;
    logic [ROW_WIDTH-1:0]         out_row;
    logic [N*ACC_WIDTH-1:0]       out_acc;
    logic [N*DATA_WIDTH-1:0]      out_quant;

    modport slave (
        input  tile_valid, a_data, b_data, out_ready,
        output tile_ready, out_valid, out_row, out_acc, out_quant
    );

    modport master (
        output tile_valid, a_data, b_data, out_ready,
        input  tile_ready, out_valid, out_row, out_acc, out_quant
    );
endinterface

// File: rtl/inference_tile_engine.sv
// Tile inference engine: an output-stationary systolic array plus K-tile accumulation,
// bias/ReLU/rounding/requantization post-processing and a row-streaming output buffer.

module systolic_array #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [N*N*DATA_WIDTH-1:0]  a_i,
    input  logic [N*N*DATA_WIDTH-1:0]  b_i,
    output logic                       done_o,
    output logic [N*N*ACC_WIDTH-1:0]   c_o
);
    localparam int CW = $clog2(3 * N);
    localparam logic [CW-1:0] LAST_CYC = CW'(3 * N - 3);

    logic          running_q;
    logic [CW-1:0] cyc_q;
    logic          done_q;

    logic signed [DATA_WIDTH-1:0] a_west  [N];
    logic signed [DATA_WIDTH-1:0] b_north [N];
    logic signed [DATA_WIDTH-1:0] a_pe    [N][N];
    logic signed [DATA_WIDTH-1:0] b_pe    [N][N];

    // The last product lands in PE(N-1,N-1) on cycle 3N-3 of the skewed feed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            cyc_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                running_q <= 1'b1;
                cyc_q     <= '0;
            end else if (running_q) begin
                if (cyc_q == LAST_CYC) begin
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end else begin
                    cyc_q <= cyc_q + 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_edge
            logic signed [DATA_WIDTH-1:0] a_edge;
            logic signed [DATA_WIDTH-1:0] b_edge;

            // Row gi of A and column gi of B enter skewed by gi cycles.
            always_comb begin
                a_edge = '0;
                b_edge = '0;
                for (int k = 0; k < N; k++) begin
                    if (running_q && (cyc_q == CW'(gi + k))) begin
                        a_edge = a_i[(gi*N + k)*DATA_WIDTH +: DATA_WIDTH];
                        b_edge = b_i[(k*N + gi)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end

            assign a_west[gi]  = a_edge;
            assign b_north[gi] = b_edge;
        end

        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                logic signed [DATA_WIDTH-1:0]   a_in;
                logic signed [DATA_WIDTH-1:0]   b_in;
                logic signed [DATA_WIDTH-1:0]   a_q;
                logic signed [DATA_WIDTH-1:0]   b_q;
                logic signed [2*DATA_WIDTH-1:0] prod;
                logic signed [ACC_WIDTH-1:0]    acc_q;

                if (gj == 0) begin : g_a_edge
                    assign a_in = a_west[gi];
                end else begin : g_a_pass
                    assign a_in = a_pe[gi][gj-1];
                end

                if (gi == 0) begin : g_b_edge
                    assign b_in = b_north[gj];
                end else begin : g_b_pass
                    assign b_in = b_pe[gi-1][gj];
                end

                assign prod = a_in * b_in;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_q   <= '0;
                        b_q   <= '0;
                        acc_q <= '0;
                    end else if (start_i) begin
                        a_q   <= '0;
                        b_q   <= '0;
                        acc_q <= '0;
                    end else if (running_q) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        acc_q <= acc_q + ACC_WIDTH'(prod);
                    end
                end

                assign a_pe[gi][gj] = a_q;
                assign b_pe[gi][gj] = b_q;
                assign c_o[(gi*N + gj)*ACC_WIDTH +: ACC_WIDTH] = acc_q;
            end
        end
    endgenerate
endmodule

module inference_tile_engine #(
    parameter int N           = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int KT_WIDTH    = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [KT_WIDTH-1:0]        num_k_tiles,
    input  logic                       enable_bias,
    input  logic                       enable_relu,
    input  logic                       enable_requant,
    input  logic                       enable_round,
    input  logic [SHIFT_WIDTH-1:0]     shift_amount,
    input  logic [N*ACC_WIDTH-1:0]     bias_data,
    inference_tile_engine_if.slave     bus,
    output logic                       busy,
    output logic                       done,
    output logic [2:0]                 state_out
);
    localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_ONE = ACC_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] QMAX    = ACC_WIDTH'((2 ** (DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] QMIN    = -QMAX - ACC_ONE;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TILE = 3'd1,
        S_MATMUL    = 3'd2,
        S_ACCUM     = 3'd3,
        S_POST      = 3'd4,
        S_STREAM    = 3'd5
    } state_t;

    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] x,
        input logic signed [ACC_WIDTH-1:0] y
    );
        logic signed [ACC_WIDTH:0] s;
        s = {x[ACC_WIDTH-1], x} + {y[ACC_WIDTH-1], y};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        return s[ACC_WIDTH-1:0];
    endfunction

    state_t state_q, state_d;

    logic [KT_WIDTH-1:0]          kcount_q;
    logic [KT_WIDTH-1:0]          kcnt_q;
    logic                         en_bias_q, en_relu_q, en_requant_q, en_round_q;
    logic [SHIFT_WIDTH-1:0]       shift_q;
    logic signed [ACC_WIDTH-1:0]  bias_q [N];
    logic signed [ACC_WIDTH-1:0]  acc_q  [N][N];
    logic [N*N*DATA_WIDTH-1:0]    a_op_q, b_op_q;
    logic                         arr_start_q;
    logic                         tile_ready_q;
    logic                         out_valid_q;
    logic                         done_q;
    logic [ROW_W-1:0]             row_q;
    logic signed [ACC_WIDTH-1:0]  buf_acc_q   [N][N];
    logic [DATA_WIDTH-1:0]        buf_quant_q [N][N];

    logic                         arr_done;
    logic [N*N*ACC_WIDTH-1:0]     arr_c;
    logic signed [ACC_WIDTH-1:0]  tile_res   [N][N];
    logic signed [ACC_WIDTH-1:0]  post_acc   [N][N];
    logic [DATA_WIDTH-1:0]        post_quant [N][N];

    logic tile_hs, out_hs, last_row, last_tile;

    assign tile_hs   = (state_q == S_WAIT_TILE) && bus.tile_valid && tile_ready_q;
    assign out_hs    = (state_q == S_STREAM) && out_valid_q && bus.out_ready;
    assign last_row  = (row_q == ROW_W'(N - 1));
    assign last_tile = ((kcnt_q + 1'b1) == kcount_q);

    systolic_array #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (arr_start_q),
        .a_i     (a_op_q),
        .b_i     (b_op_q),
        .done_o  (arr_done),
        .c_o     (arr_c)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_WAIT_TILE;
            S_WAIT_TILE: if (tile_hs) state_d = S_MATMUL;
            S_MATMUL:    if (arr_done) state_d = S_ACCUM;
            S_ACCUM:     state_d = last_tile ? S_POST : S_WAIT_TILE;
            S_POST:      state_d = S_STREAM;
            S_STREAM:    if (out_hs && last_row) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            kcount_q     <= '0;
            kcnt_q       <= '0;
            en_bias_q    <= 1'b0;
            en_relu_q    <= 1'b0;
            en_requant_q <= 1'b0;
            en_round_q   <= 1'b0;
            shift_q      <= '0;
            a_op_q       <= '0;
            b_op_q       <= '0;
            arr_start_q  <= 1'b0;
            tile_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            row_q        <= '0;
            for (int i = 0; i < N; i++) begin
                bias_q[i] <= '0;
                for (int j = 0; j < N; j++) begin
                    acc_q[i][j]       <= '0;
                    buf_acc_q[i][j]   <= '0;
                    buf_quant_q[i][j] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            tile_ready_q <= (state_d == S_WAIT_TILE);
            out_valid_q  <= (state_d == S_STREAM);
            done_q       <= out_hs && last_row;
            arr_start_q  <= tile_hs;

            if ((state_q == S_IDLE) && start) begin
                kcount_q     <= (num_k_tiles == '0) ? KT_WIDTH'(1) : num_k_tiles;
                kcnt_q       <= '0;
                en_bias_q    <= enable_bias;
                en_relu_q    <= enable_relu;
                en_requant_q <= enable_requant;
                en_round_q   <= enable_round;
                shift_q      <= shift_amount;
                for (int i = 0; i < N; i++) begin
                    bias_q[i] <= bias_data[i*ACC_WIDTH +: ACC_WIDTH];
                    for (int j = 0; j < N; j++) acc_q[i][j] <= '0;
                end
            end

            if (tile_hs) begin
                a_op_q <= bus.a_data;
                b_op_q <= bus.b_data;
            end

            if (state_q == S_ACCUM) begin
                kcnt_q <= kcnt_q + 1'b1;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        acc_q[i][j] <= sat_add(acc_q[i][j], tile_res[i][j]);
            end

            if (state_q == S_POST) begin
                row_q <= '0;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        buf_acc_q[i][j]   <= post_acc[i][j];
                        buf_quant_q[i][j] <= post_quant[i][j];
                    end
            end

            if (out_hs) row_q <= last_row ? '0 : row_q + 1'b1;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pr
            for (gj = 0; gj < N; gj++) begin : g_pc
                logic signed [ACC_WIDTH-1:0] biased, relu_v, rounded, shifted, clamped;
                logic [DATA_WIDTH-1:0]       quant_v;

                assign tile_res[gi][gj] = arr_c[(gi*N + gj)*ACC_WIDTH +: ACC_WIDTH];

                // Unrequantized output keeps the low bits of the ReLU value, not the shifted one.
                always_comb begin
                    biased  = en_bias_q ? sat_add(acc_q[gi][gj], bias_q[gj]) : acc_q[gi][gj];
                    relu_v  = (en_relu_q && biased[ACC_WIDTH-1]) ? '0 : biased;
                    rounded = (en_round_q && (shift_q != '0))
                            ? sat_add(relu_v, ACC_ONE << (shift_q - 1'b1)) : relu_v;
                    shifted = rounded >>> shift_q;
                    if (shifted > QMAX)      clamped = QMAX;
                    else if (shifted < QMIN) clamped = QMIN;
                    else                     clamped = shifted;
                    quant_v = en_requant_q ? clamped[DATA_WIDTH-1:0] : relu_v[DATA_WIDTH-1:0];
                end

                assign post_acc[gi][gj]   = relu_v;
                assign post_quant[gi][gj] = quant_v;
            end
        end

        for (gj = 0; gj < N; gj++) begin : g_out
            assign bus.out_acc[gj*ACC_WIDTH +: ACC_WIDTH]     = buf_acc_q[row_q][gj];
            assign bus.out_quant[gj*DATA_WIDTH +: DATA_WIDTH] = buf_quant_q[row_q][gj];
        end
    endgenerate

    assign bus.tile_ready = tile_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_row    = row_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign state_out      = state_q;
endmodule

// File: tb/tb_inference_tile_engine.sv
// Directed, table-driven bench for inference_tile_engine (N=4, int8 operands, int32 accumulation).
module tb_inference_tile_engine;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [7:0]   num_k_tiles;
    logic         enable_bias, enable_relu, enable_requant, enable_round;
    logic [4:0]   shift_amount;
    logic [127:0] bias_data;
    logic         busy, done;
    logic [2:0]   state_out;

    int total = 0;
    int bad   = 0;

    inference_tile_engine_if #(.N(4), .DATA_WIDTH(8), .ACC_WIDTH(32)) bus ();

    inference_tile_engine #(
        .N(4), .DATA_WIDTH(8), .ACC_WIDTH(32), .KT_WIDTH(8), .SHIFT_WIDTH(5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .num_k_tiles    (num_k_tiles),
        .enable_bias    (enable_bias),
        .enable_relu    (enable_relu),
        .enable_requant (enable_requant),
        .enable_round   (enable_round),
        .shift_amount   (shift_amount),
        .bias_data      (bias_data),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .state_out      (state_out)
    );

    always #5 clk = ~clk;

    // en = {bias, relu, requant, round}; exp_* packed so element [j] is column j
    typedef struct {
        int               k_cfg;
        int               k_feed;
        int               gap;
        bit               a_ident;
        logic signed [7:0] a_val;
        bit               b_ramp;
        logic signed [7:0] b_val;
        logic [3:0]       en;
        int               shift;
        logic [3:0][31:0] bias;
        logic [3:0][31:0] exp_acc;
        logic [3:0][7:0]  exp_q;
    } vec_t;

    localparam logic [31:0]       M10   = -32'sd10;
    localparam logic [31:0]       M6    = -32'sd6;
    localparam logic [31:0]       M5    = -32'sd5;
    localparam logic [31:0]       M24   = -32'sd24;
    localparam logic [31:0]       M200  = -32'sd200;
    localparam logic [31:0]       M198  = -32'sd198;
    localparam logic signed [7:0] N5    = -8'sd5;
    localparam logic signed [7:0] N1    = -8'sd1;

    vec_t vecs [13];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_tile(input vec_t v);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                bus.a_data[(i*4 + k)*8 +: 8] = v.a_ident ? ((i == k) ? 8'd1 : 8'd0) : v.a_val;
                bus.b_data[(i*4 + k)*8 +: 8] = v.b_ramp ? 8'(k + 1) : v.b_val;
            end
    endtask

    task automatic send_tile(input vec_t v, input int gap);
        int w;
        bus.tile_valid = 1'b0;
        repeat (gap) tick();
        load_tile(v);
        bus.tile_valid = 1'b1;
        w = 0;
        while (!bus.tile_ready && w < 200) begin
            tick();
            w++;
        end
        check("tile_accept", 128'(bus.tile_ready), 128'(1));
        tick();
        bus.tile_valid = 1'b0;
        bus.a_data = {4{$urandom()}};
        bus.b_data = {4{$urandom()}};
        check("tile_ready_drop", 128'(bus.tile_ready), 128'(0));
    endtask

    task automatic start_job(input vec_t v);
        num_k_tiles    = 8'(v.k_cfg);
        enable_bias    = v.en[3];
        enable_relu    = v.en[2];
        enable_requant = v.en[1];
        enable_round   = v.en[0];
        shift_amount   = 5'(v.shift);
        bias_data      = v.bias;
        start          = 1'b1;
        tick();
        start          = 1'b0;
        num_k_tiles    = 8'd9;
        enable_bias    = ~enable_bias;
        enable_relu    = ~enable_relu;
        enable_requant = ~enable_requant;
        enable_round   = ~enable_round;
        shift_amount   = 5'd7;
        bias_data      = {4{32'h0001_2345}};
        check("start_state", 128'(state_out), 128'(1));
    endtask

    task automatic wait_valid;
        int w;
        w = 0;
        while (!bus.out_valid && w < 100) begin
            tick();
            w++;
        end
        check("out_valid", 128'(bus.out_valid), 128'(1));
    endtask

    task automatic collect_rows(input vec_t v, input int bp_row);
        bus.out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            wait_valid();
            check("out_row", 128'(bus.out_row), 128'(r));
            check("out_acc", 128'(bus.out_acc), 128'(v.exp_acc));
            check("out_quant", 128'(bus.out_quant), 128'(v.exp_q));
            if (r == bp_row) begin
                bus.out_ready = 1'b0;
                start         = 1'b1;
                num_k_tiles   = 8'd5;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    start = 1'b0;
                    check("stall_row", 128'(bus.out_row), 128'(r));
                    check("stall_acc", 128'(bus.out_acc), 128'(v.exp_acc));
                    check("stall_quant", 128'(bus.out_quant), 128'(v.exp_q));
                    check("stall_state", 128'(state_out), 128'(5));
                end
                bus.out_ready = 1'b1;
            end
            tick();
        end
        check("done_pulse", 128'(done), 128'(1));
        check("valid_drop", 128'(bus.out_valid), 128'(0));
        tick();
        check("done_single", 128'(done), 128'(0));
        check("back_idle", 128'(state_out), 128'(0));
    endtask

    task automatic run_job(input int idx, input int bp_row);
        vec_t v;
        int   bad_before;
        v = vecs[idx];
        bad_before = bad;
        start_job(v);
        for (int t = 0; t < v.k_feed; t++) send_tile(v, v.gap);
        collect_rows(v, bp_row);
        $display("job %0d: k_cfg=%0d tiles=%0d stall_row=%0d new_errors=%0d",
                 idx, v.k_cfg, v.k_feed, bp_row, bad - bad_before);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1, 1, 0, 1'b1, 8'sd0, 1'b0, 8'sd2,   4'b0000, 0, 128'd0,
                     {4{32'd2}}, {4{8'h02}}};
        vecs[1]  = '{3, 3, 2, 1'b0, 8'sd1, 1'b0, 8'sd1,   4'b0000, 0, 128'd0,
                     {4{32'd12}}, {4{8'h0C}}};
        vecs[2]  = '{1, 1, 0, 1'b1, 8'sd0, 1'b0, 8'sd4,   4'b1100, 0, {4{M10}},
                     {4{32'd0}}, {4{8'h00}}};
        vecs[3]  = '{1, 1, 0, 1'b1, 8'sd0, 1'b0, 8'sd4,   4'b1000, 0, {4{M10}},
                     {4{M6}}, {4{8'hFA}}};
        vecs[4]  = '{1, 1, 0, 1'b1, 8'sd0, 1'b0, 8'sd5,   4'b0011, 1, 128'd0,
                     {4{32'd5}}, {4{8'h03}}};
        vecs[5]  = '{1, 1, 0, 1'b1, 8'sd0, 1'b0, 8'sd5,   4'b0010, 1, 128'd0,
                     {4{32'd5}}, {4{8'h02}}};
        vecs[6]  = '{1, 1, 0, 1'b1, 8'sd0, 1'b0, N5,      4'b0011, 1, 128'd0,
                     {4{M5}}, {4{8'hFE}}};
        vecs[7]  = '{1, 1, 0, 1'b1, 8'sd0, 1'b0, N5,      4'b0010, 1, 128'd0,
                     {4{M5}}, {4{8'hFD}}};
        vecs[8]  = '{1, 1, 0, 1'b0, 8'sd2, 1'b0, 8'sd125, 4'b0010, 2, 128'd0,
                     {4{32'd1000}}, {4{8'h7F}}};
        vecs[9]  = '{1, 1, 0, 1'b1, 8'sd0, 1'b0, 8'sd32,  4'b1000, 0, {4{32'h7FFF_FFF0}},
                     {4{32'h7FFF_FFFF}}, {4{8'hFF}}};
        vecs[10] = '{0, 1, 0, 1'b1, 8'sd0, 1'b0, 8'sd7,   4'b0000, 0, 128'd0,
                     {4{32'd7}}, {4{8'h07}}};
        vecs[11] = '{1, 1, 1, 1'b1, 8'sd0, 1'b1, 8'sd0,   4'b1010, 0,
                     {32'd5, 32'd0, M200, 32'd100},
                     {32'd9, 32'd3, M198, 32'd101}, {8'h09, 8'h03, 8'h80, 8'h65}};
        vecs[12] = '{2, 2, 1, 1'b0, N1,    1'b0, 8'sd3,   4'b0010, 0, 128'd0,
                     {4{M24}}, {4{8'hE8}}};

        rst_n          = 1'b0;
        start          = 1'b0;
        num_k_tiles    = 8'd0;
        enable_bias    = 1'b0;
        enable_relu    = 1'b0;
        enable_requant = 1'b0;
        enable_round   = 1'b0;
        shift_amount   = 5'd0;
        bias_data      = 128'd0;
        bus.tile_valid = 1'b0;
        bus.a_data     = '0;
        bus.b_data     = '0;
        bus.out_ready  = 1'b0;

        repeat (3) tick();
        check("rst_state", 128'(state_out), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_valid", 128'(bus.out_valid), 128'(0));
        check("rst_tile_ready", 128'(bus.tile_ready), 128'(0));
        check("rst_acc", 128'(bus.out_acc), 128'(0));
        check("rst_quant", 128'(bus.out_quant), 128'(0));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) run_job(i, (i == 11) ? 1 : -1);

        // Reset asserted while a row is being presented
        start_job(vecs[0]);
        send_tile(vecs[0], 0);
        bus.out_ready = 1'b0;
        wait_valid();
        check("abort_in_stream", 128'(state_out), 128'(5));
        rst_n = 1'b0;
        #1;
        check("abort_valid", 128'(bus.out_valid), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        check("abort_state", 128'(state_out), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_idle_done", 128'(done), 128'(0));
        $display("job abort: reset during stream");

        run_job(0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
